// File: rtl/datamem_arbiter.sv
// Two-port arbiter and sequencer for the shared data RAM.
// Each request: grant, one ACCESS cycle, one RESP cycle with ack.
module datamem_arbiter #(
  parameter int RAM_SIZE   = 256,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p1_req,
  input  logic        p0_wr,
  input  logic        p1_wr,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p0_wdata,
  input  logic [31:0] p1_wdata,
  output logic [31:0] p0_rdata,
  output logic [31:0] p1_rdata,
  output logic        p0_ack,
  output logic        p1_ack,
  output logic        p0_err,
  output logic        p1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [29:0] DEPTH = 30'(RAM_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t      state;
  logic        id;
  logic        wr;
  logic        bad;
  logic        last;
  logic [1:0]  cand;
  logic        gnt_id;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_wr;
  logic        sel_bad;
  logic [31:0] rd_val;

  // The port being acked in RESP cannot be re-granted back to back.
  always_comb begin
    cand = {p1_req, p0_req};
    if (state == RESP) cand[id] = 1'b0;
    if (state == ACCESS) cand = 2'b00;
    case (cand)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = FIXED_PRIO ? 1'b0 : ~last;
      default: gnt_id = 1'b0;
    endcase
    sel_addr  = gnt_id ? p1_addr : p0_addr;
    sel_wdata = gnt_id ? p1_wdata : p0_wdata;
    sel_wr    = gnt_id ? p1_wr : p0_wr;
    sel_bad   = (sel_addr[31:2] >= DEPTH) |
                (sel_addr[1:0] != 2'b00);
    rd_val    = (!wr && !bad) ? mem_rdata : 32'h0;
  end

  assign busy   = (state != IDLE);
  assign mem_rd = (state == ACCESS) & ~wr & ~bad;
  assign mem_wr = (state == ACCESS) & wr & ~bad & reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      id        <= 1'b0;
      wr        <= 1'b0;
      bad       <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p0_err    <= 1'b0;
      p1_err    <= 1'b0;
      p0_rdata  <= 32'h0;
      p1_rdata  <= 32'h0;
    end else begin
      p0_ack   <= 1'b0;
      p1_ack   <= 1'b0;
      p0_err   <= 1'b0;
      p1_err   <= 1'b0;
      p0_rdata <= 32'h0;
      p1_rdata <= 32'h0;
      case (state)
        ACCESS: begin
          state <= RESP;
          if (id) begin
            p1_ack   <= 1'b1;
            p1_err   <= bad;
            p1_rdata <= rd_val;
          end else begin
            p0_ack   <= 1'b1;
            p0_err   <= bad;
            p0_rdata <= rd_val;
          end
        end
        IDLE, RESP: begin
          if (cand != 2'b00) begin
            state     <= ACCESS;
            id        <= gnt_id;
            last      <= gnt_id;
            wr        <= sel_wr;
            bad       <= sel_bad;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/datamem_arbiter.md
# datamem_arbiter

Two-port arbiter and sequencer for the single-cycle CPU's data memory. It shares one word-addressed data RAM (combinational read, write on rising `clk`) between the CPU load/store port (port 0) and a peripheral/DMA port (port 1). Each request is latched, range-checked, issued to the RAM for exactly one cycle, and answered with a one-cycle `ack` and registered read data. The block sits between the requesters and the data memory, and drives all memory control signals.

## Interface
- `RAM_SIZE`, 256, RAM depth in 32-bit words; valid word index is `addr[31:2] < RAM_SIZE`.
- `FIXED_PRIO`, 0, 1 = port 0 always wins a tie; 0 = round-robin between ports.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `p0_req`, `p1_req`  in  1  request; held high with fields stable until the matching ack.
- `p0_wr`, `p1_wr`  in  1  1 = write, 0 = read.
- `p0_addr`, `p1_addr`  in  32  byte address (word-aligned).
- `p0_wdata`, `p1_wdata`  in  32  write data.
- `p0_rdata`, `p1_rdata`  out  32  registered read data, valid while the matching ack is high.
- `p0_ack`, `p1_ack`  out  1  one-cycle completion pulse.
- `p0_err`, `p1_err`  out  1  pulses with ack when the request was out of range or misaligned.
- `mem_addr`  out  32  RAM address.
- `mem_wdata`  out  32  RAM write data.
- `mem_rd`  out  1  RAM read enable.
- `mem_wr`  out  1  RAM write enable.
- `mem_rdata`  in  32  RAM combinational read data.
- `busy`  out  1  high in ACCESS and RESP states.

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - ACCESS: latched request is driven to the RAM.
  - RESP: ack and read data returned to the served port.
- Arbitration, evaluated in IDLE and RESP:
  - Candidates are ports with `req` high. In RESP, the port being acked is masked out.
  - One candidate: grant it.
  - Two candidates: `FIXED_PRIO=1` grants port 0. `FIXED_PRIO=0` grants the port not served last.
  - `last` pointer resets to 1, so port 0 wins the first tie.
- On grant:
  - Latch id, wr, addr and wdata.
  - Compute `bad = (addr[31:2] >= RAM_SIZE) | (addr[1:0] != 0)`.
  - Go to ACCESS and update `last`.
- ACCESS:
  - `mem_addr` and `mem_wdata` come from the latched values.
  - `mem_rd = !wr & !bad`; `mem_wr = wr & !bad & reset`.
  - At the clock edge, the read data register captures `mem_rdata` (reads) or 0 (writes or bad requests).
  - Always go to RESP.
- RESP:
  - Served port's ack is 1; its err equals `bad`; its rdata equals the captured value.
  - Other port's ack, err and rdata are 0.
  - Next state is ACCESS if another candidate is granted, else IDLE.
- Outside ACCESS, `mem_rd` and `mem_wr` are 0. `mem_addr` and `mem_wdata` hold their latched values (don't-care).
- Bad request: no RAM access at all (both enables 0), rdata 0, err 1.

## Timing
- Reset (`reset` low at an edge):
  - State becomes IDLE and `last` becomes 1.
  - All outputs go to 0: acks, errs, rdata, `mem_rd`, `mem_wr`, `mem_addr`, `mem_wdata`, `busy`.
  - A write in ACCESS during a reset cycle does not commit (`mem_wr` is gated by `reset`).
  - Requests are ignored while `reset` is low.
- Latency: request first seen high in IDLE in cycle N → ACCESS in N+1 (the write commits at the end of N+1) → ack in N+2.
- Back-to-back (alternating ports): one transaction every 2 cycles.
- Same port repeatedly: every 3 cycles, because its req is masked during its own RESP.
- A requester may drop req the cycle after ack, or keep it high to queue the next access. Fields must then be updated in the ack cycle.
- Req dropped before ack: undefined; not supported.

## Test plan
- Read: preload RAM[5]=0xDEADBEEF; p0 read addr 0x14 at cycle 1 → `mem_rd`=1 in cycle 2, `p0_ack`=1 with `p0_rdata`=0xDEADBEEF in cycle 3, IDLE in cycle 4.
- Write-then-read: p1 write 0x12345678 to 0x3FC → RAM[255] updated at the end of ACCESS, `p1_ack` with rdata 0. p1 read 0x3FC → 0x12345678.
- Contention, `FIXED_PRIO=0`: both ports request continuously → acks in the order p0, p1, p0, p1 at cycles 3, 5, 7, 9. With `FIXED_PRIO=1`, p0 wins every tie, and p1 is served only in p0's RESP cycles.
- Errors: p0 write to 0x400 (with `RAM_SIZE`=256), and p0 read of 0x13 → `mem_wr`/`mem_rd` stay 0, RAM unchanged, `p0_ack`=`p0_err`=1, rdata 0.
- Reset mid-operation: assert `reset`=0 during the ACCESS cycle of a write → target word unchanged, all outputs 0 the next cycle, no ack. After release, a fresh request completes normally.
- Idle hold: no req for 20 cycles → `busy`, `mem_rd`, `mem_wr` and all acks stay 0.
